// File: rtl/seq_gcd_unit_if.sv
// -----------------------------------------------------------------------------
// seq_gcd_unit_if
//
// Request/response bundle between the LA request/response adapter and the
// seq_gcd_unit GCD engine.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. Once the source raises valid it keeps
// valid and its payload stable until that edge. The sink may drive ready
// without looking at valid.
//
// Signals:
//   req_val      adapter -> engine  operands valid
//   req_rdy      engine  -> adapter engine can accept operands
//   req_a        adapter -> engine  operand A
//   req_b        adapter -> engine  operand B
//   resp_val     engine  -> adapter result valid
//   resp_rdy     adapter -> engine  adapter accepts the result
//   resp_result  engine  -> adapter gcd(A,B)
//
// Modports:
//   master : the adapter side, which issues requests and consumes responses
//   slave  : the engine side
// -----------------------------------------------------------------------------
interface seq_gcd_unit_if #(
    parameter int W = 32
);
    logic         req_val;
    logic         req_rdy;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         resp_val;
    logic         resp_rdy;
    logic [W-1:0] resp_result;

    modport master (
        output req_val,
        input  req_rdy,
        output req_a,
        output req_b,
        input  resp_val,
        output resp_rdy,
        input  resp_result
    );

    modport slave (
        input  req_val,
        output req_rdy,
        input  req_a,
        input  req_b,
        output resp_val,
        input  resp_rdy,
        output resp_result
    );
endinterface

// File: rtl/seq_gcd_unit.sv
// -----------------------------------------------------------------------------
// seq_gcd_unit
//
// Sequential binary (Stein) GCD engine. One operand pair is in flight at a
// time. The engine accepts a pair in IDLE and performs one reduction step per
// clock in CALC. It then presents the result in DONE until the consumer takes
// it.
//
// Ports:
//   wb_clk_i     in   clock, all state updates on the rising edge
//   wb_rst_i     in   asynchronous active-high reset
//   bus          slave modport of seq_gcd_unit_if (request/response channels)
//   busy         out  high while in CALC
//   cycle_count  out  CALC steps used by the last or current operation
//                     (saturating)
//   state        out  current FSM state, exposed for debug and checkers
//
// Parameters:
//   W   operand/result width
//   KW  width of the shared power-of-two counter k; needs clog2(W)+1 bits
//   CW  width of the debug cycle counter
// -----------------------------------------------------------------------------
module seq_gcd_unit #(
    parameter int W  = 32,
    parameter int KW = 6,
    parameter int CW = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    seq_gcd_unit_if.slave        bus,
    output logic                 busy,
    output logic [CW-1:0]        cycle_count,
    output logic [1:0]           state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [KW-1:0] K_ONE   = {{(KW-1){1'b0}}, 1'b1};

    logic [1:0]    st_q,  st_n;
    logic [W-1:0]  a_q,   a_n;
    logic [W-1:0]  b_q,   b_n;
    logic [KW-1:0] k_q,   k_n;
    logic [W-1:0]  res_q, res_n;
    logic [CW-1:0] cnt_q, cnt_n;

    // The odd-odd step only uses the difference in the non-negative
    // direction, so at most one of these is ever selected.
    logic [W-1:0]  diff_ab;
    logic [W-1:0]  diff_ba;

    assign diff_ab = a_q - b_q;
    assign diff_ba = b_q - a_q;

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        st_n  = st_q;
        a_n   = a_q;
        b_n   = b_q;
        k_n   = k_q;
        res_n = res_q;
        cnt_n = cnt_q;

        case (st_q)
            S_IDLE: begin
                // req_rdy is high throughout IDLE, so req_val alone marks
                // the accept edge.
                if (bus.req_val) begin
                    a_n   = bus.req_a;
                    b_n   = bus.req_b;
                    k_n   = '0;
                    cnt_n = '0;
                    st_n  = S_CALC;
                end
            end

            S_CALC: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_n = cnt_q + CNT_ONE;
                end

                if (a_q == '0) begin
                    // The true gcd fits in W bits, so shifting back by k
                    // cannot lose bits.
                    res_n = b_q << k_q;
                    st_n  = S_DONE;
                end else if (b_q == '0) begin
                    res_n = a_q << k_q;
                    st_n  = S_DONE;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_n = a_q >> 1;
                    b_n = b_q >> 1;
                    k_n = k_q + K_ONE;
                end else if (!a_q[0]) begin
                    a_n = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_n = b_q >> 1;
                end else if (a_q >= b_q) begin
                    // odd - odd is even, so one halving always applies
                    a_n = diff_ab >> 1;
                end else begin
                    b_n = diff_ba >> 1;
                end
            end

            S_DONE: begin
                if (bus.resp_rdy) begin
                    st_n = S_IDLE;
                end
            end

            default: begin
                st_n = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            st_q  <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            k_q   <= '0;
            res_q <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_n;
            a_q   <= a_n;
            b_q   <= b_n;
            k_q   <= k_n;
            res_q <= res_n;
            cnt_q <= cnt_n;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded from registered state, with no input-to-output
    // combinational path.
    // -------------------------------------------------------------------------
    assign bus.req_rdy     = (st_q == S_IDLE);
    assign bus.resp_val    = (st_q == S_DONE);
    assign bus.resp_result = res_q;
    assign busy            = (st_q == S_CALC);
    assign cycle_count     = cnt_q;
    assign state           = st_q;

endmodule

// File: tb/tb_seq_gcd_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_gcd_unit
//
// Directed testbench for seq_gcd_unit. Inputs are driven and outputs sampled
// on the falling clock edge. Expected results come from hand-computed values
// that are pushed into exp_q and popped when each response appears.
// -----------------------------------------------------------------------------
module tb_seq_gcd_unit;

    localparam int W  = 32;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          busy;
    logic [CW-1:0] cycle_count;
    logic [1:0]    state;

    seq_gcd_unit_if #(.W(W)) bus ();

    seq_gcd_unit #(.W(W), .KW(6), .CW(CW)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .bus         (bus),
        .busy        (busy),
        .cycle_count (cycle_count),
        .state       (state)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ scoreboard
    int unsigned    n_vec  = 0;
    int unsigned    n_fail = 0;
    logic [W-1:0]   exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // --------------------------------------------------------------- drivers
    task automatic do_reset();
        rst          = 1'b1;
        bus.req_val  = 1'b0;
        bus.req_a    = '0;
        bus.req_b    = '0;
        bus.resp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Present one operand pair and push its expected result. Returns at the
    // falling edge just after the accept edge, with req_a/req_b scrambled so
    // that late sampling would show up as a wrong result.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_res);
        int guard;
        guard = 0;
        while (!bus.req_rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("req_rdy_before_accept", bus.req_rdy, 1'b1);
        exp_q.push_back(exp_res);
        bus.req_val = 1'b1;
        bus.req_a   = a;
        bus.req_b   = b;
        @(negedge clk);
        bus.req_val = 1'b0;
        bus.req_a   = $urandom;
        bus.req_b   = $urandom;
    endtask

    // Wait for the response, check it and consume it. When noisy is set,
    // req_val and the operands are toggled while the engine works. exp_cyc < 0
    // skips the exact cycle-count check.
    task automatic finish_op(input string tag, input int exp_cyc, input bit noisy,
                             output int edges);
        logic [W-1:0] exp_res;
        bit           ctl_ok;
        ctl_ok = 1'b1;
        edges  = 0;
        while (!bus.resp_val && edges < 200) begin
            if (!busy || bus.req_rdy) ctl_ok = 1'b0;
            if (noisy) begin
                bus.req_val = 1'($urandom_range(0, 1));
                bus.req_a   = $urandom;
                bus.req_b   = $urandom;
            end
            @(negedge clk);
            edges++;
        end
        bus.req_val = 1'b0;
        check({tag, "_timeout"}, (edges < 200), 1'b1);
        check({tag, "_busy_rdy_in_calc"}, ctl_ok, 1'b1);
        exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_result"}, bus.resp_result, exp_res);
        check({tag, "_latency_eq_count"}, edges, cycle_count);
        if (exp_cyc >= 0) check({tag, "_cycles"}, cycle_count, exp_cyc);
        check({tag, "_busy_done"}, busy, 1'b0);
        check({tag, "_req_rdy_done"}, bus.req_rdy, 1'b0);
        bus.resp_rdy = 1'b1;
        @(negedge clk);
        bus.resp_rdy = 1'b0;
        check({tag, "_req_rdy_after"}, bus.req_rdy, 1'b1);
        check({tag, "_resp_val_after"}, bus.resp_val, 1'b0);
    endtask

    // --------------------------------------------------------------- stimulus
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;
    } vec_t;

    vec_t fw_vecs[5];

    initial begin
        int edges;
        bit stable;
        bit extra_resp;
        logic [W-1:0]  held_res;
        logic [CW-1:0] held_cnt;

        fw_vecs[0] = '{32'd10312050,   32'd29460792,   32'd138};
        fw_vecs[1] = '{32'd1993627629, 32'd1177417612, 32'd7};
        fw_vecs[2] = '{32'd2097015289, 32'd3812041926, 32'd1};
        fw_vecs[3] = '{32'd1924134885, 32'd3151131255, 32'd135};
        fw_vecs[4] = '{32'd992211318,  32'd512609597,  32'd1};

        do_reset();
        check("rst_req_rdy",     bus.req_rdy,     1'b1);
        check("rst_resp_val",    bus.resp_val,    1'b0);
        check("rst_busy",        busy,            1'b0);
        check("rst_cycle_count", cycle_count,     0);
        check("rst_result",      bus.resp_result, 0);

        // 48,18: 7 steps (both-even, 3x a-even, b=(9-3)/2, a=0, a==0)
        start_op(32'd48, 32'd18, 32'd6);
        finish_op("g48_18", 7, 1'b0, edges);
        check("g48_18_edges", edges, 7);

        // firmware vectors back to back
        foreach (fw_vecs[i]) begin
            start_op(fw_vecs[i].a, fw_vecs[i].b, fw_vecs[i].g);
            finish_op($sformatf("fw%0d", i), -1, 1'b0, edges);
            check($sformatf("fw%0d_cyc_le_65", i), (cycle_count <= 65), 1'b1);
        end

        // edge operands
        start_op(32'd0, 32'd0, 32'd0);
        finish_op("g0_0", 1, 1'b0, edges);
        start_op(32'd0, 32'd42, 32'd42);
        finish_op("g0_42", 1, 1'b0, edges);
        start_op(32'd42, 32'd0, 32'd42);
        finish_op("g42_0", 1, 1'b0, edges);
        // odd-odd equal step zeroes a, then a==0 returns b
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("gffff", 2, 1'b0, edges);
        // 30 both-even steps, a even, odd-odd, a==0 -> 1<<30
        start_op(32'h8000_0000, 32'h4000_0000, 32'h4000_0000);
        finish_op("gpow2", 33, 1'b0, edges);

        // backpressure: hold DONE for 20 cycles
        start_op(32'd48, 32'd18, 32'd6);
        edges = 0;
        while (!bus.resp_val && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check("bp_resp_seen", bus.resp_val, 1'b1);
        held_res = bus.resp_result;
        held_cnt = cycle_count;
        stable   = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!bus.resp_val || bus.req_rdy || bus.resp_result !== held_res ||
                cycle_count !== held_cnt) stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        check("bp_result", held_res, exp_q.pop_front());
        bus.resp_rdy = 1'b1;
        @(negedge clk);
        bus.resp_rdy = 1'b0;
        check("bp_req_rdy_after", bus.req_rdy, 1'b1);
        check("bp_resp_val_after", bus.resp_val, 1'b0);

        // ignored inputs while busy: exactly one response with the original pair
        start_op(fw_vecs[0].a, fw_vecs[0].b, fw_vecs[0].g);
        finish_op("noisy", -1, 1'b1, edges);
        extra_resp = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp_val || !bus.req_rdy) extra_resp = 1'b1;
        end
        check("noisy_single_resp", extra_resp, 1'b0);

        // asynchronous reset in the middle of CALC
        start_op(fw_vecs[1].a, fw_vecs[1].b, fw_vecs[1].g);
        repeat (3) @(negedge clk);
        check("mid_busy_before", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_resp_val", bus.resp_val, 1'b0);
        check("mid_busy",     busy,         1'b0);
        check("mid_cycles",   cycle_count,  0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_req_rdy_after", bus.req_rdy, 1'b1);
        extra_resp = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp_val || busy) extra_resp = 1'b1;
        end
        check("mid_no_resp", extra_resp, 1'b0);
        start_op(32'd48, 32'd18, 32'd6);
        finish_op("post_rst", 7, 1'b0, edges);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_gcd_unit.md
Name: seq_gcd_unit

Overview:
- Sequential 32-bit binary (Stein) GCD engine inside the user project.
- Consumes operand pairs that the firmware drives over the logic-analyzer bus through the LA request/response adapter.
- Returns the result to the adapter, which reflects it to firmware and to the checkbits status handshake.
- Valid/ready handshake on both request and response sides. One operation in flight at a time.

Parameters:
- W, 32, operand and result width in bits.
- KW, 6, width of the common-power-of-two counter k; must be at least clog2(W)+1.
- CW, 8, width of the debug cycle counter; saturates at its maximum.

Ports:
- wb_clk_i  in  1  clock; all state updates on the rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- req_val  in  1  operands valid.
- req_rdy  out  1  engine can accept operands; high only in IDLE.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- resp_val  out  1  result valid.
- resp_rdy  in  1  consumer accepts the result.
- resp_result  out  W  gcd(A,B).
- busy  out  1  high in CALC.
- cycle_count  out  CW  number of CALC cycles used by the last or current operation.

Behaviour:
- Reset (async, wb_rst_i=1):
  - State goes to IDLE.
  - a, b, k, resp_result and cycle_count clear to 0.
  - req_rdy=1 once in IDLE; resp_val=0; busy=0.
  - Reset during CALC or DONE discards the operation and no response is issued.
- States:
  - IDLE: req_rdy=1. On req_val&req_rdy at edge E, latch a=req_a, b=req_b, k=0, cycle_count=0; next state CALC.
  - CALC: exactly one step per edge; cycle_count increments by 1 (saturating). The first matching rule applies:
    1. a==0: resp_result=b<<k, go to DONE.
    2. b==0: resp_result=a<<k, go to DONE.
    3. a and b both even: a>>=1, b>>=1, k+=1.
    4. a even: a>>=1.
    5. b even: b>>=1.
    6. Both odd and a>=b: a=(a-b)>>1. Otherwise: b=(b-a)>>1.
  - DONE: resp_val=1, with resp_result and cycle_count held stable. On resp_val&resp_rdy, go to IDLE. req_rdy stays 0 in DONE, so there is no same-cycle accept and a minimum one-cycle bubble between operations.
- Arithmetic:
  - The subtraction is W-bit and unsigned; the ordering guard guarantees no underflow.
  - The shift left by k cannot overflow, because the true gcd fits in W bits.
- Latency:
  - resp_val rises N edges after the accept edge E, where N = cycle_count, the number of CALC steps including the terminating step.
  - Bounded by N ≤ 2W+1 for all inputs.
- Boundary conditions:
  - gcd(0,0)=0 in 1 cycle.
  - gcd(0,x)=x and gcd(x,0)=x in 1 cycle.
  - gcd(x,x): the first odd-odd step zeroes a.
- Input sampling:
  - req_a and req_b are sampled only at the accept edge.
  - Changes to req_a/req_b while busy are ignored.
  - req_val while not in IDLE is ignored and never queued.
- Backpressure: resp_rdy held low keeps DONE indefinitely with outputs stable.
- Output decoding: busy and req_rdy are state-decoded with no combinational path from inputs.

Test Plan:
1. Reset, then A=48, B=18 -> resp_result=6, cycle_count=7, resp_val rises exactly 7 edges after accept; busy high for those 7 cycles.
2. Back-to-back firmware vectors, each expected response checked exactly:
   - (10312050, 29460792) -> 138
   - (1993627629, 1177417612) -> 7
   - (2097015289, 3812041926) -> 1
   - (1924134885, 3151131255) -> 135
   - (992211318, 512609597) -> 1
   - For every vector: cycle_count ≤ 65 and req_rdy low from accept until the response is consumed.
3. Edge operands:
   - (0,0) -> 0; (0,42) -> 42; (42,0) -> 42; each with cycle_count=1.
   - (0xFFFFFFFF, 0xFFFFFFFF) -> 0xFFFFFFFF.
   - (0x80000000, 0x40000000) -> 0x40000000.
4. Backpressure: hold resp_rdy=0 for 20 cycles after resp_val -> resp_val, resp_result and cycle_count stay constant, req_rdy stays 0; raise resp_rdy -> IDLE next edge, req_rdy=1.
5. Ignored inputs: pulse req_val with new operands during CALC and toggle req_a/req_b -> result still matches the originally accepted pair, and exactly one response is issued.
6. Mid-operation reset: assert wb_rst_i asynchronously (between edges) during CALC of (1993627629, 1177417612) -> resp_val, busy and cycle_count go to 0 immediately and req_rdy=1 after release; a following (48,18) still returns 6.
